calc_serial_tx: RTL and testbench
=================================

# calc_serial_tx

Parametrised serial transmit unit for the binary calculator output path, successor to the fixed-width transmitter/frequency-divider pair. Result words from the calculator core are buffered in a DEPTH-entry FIFO and shifted out one bit at a time on DataOut with a generated ClkTx. Width, FIFO depth, bit order and divider ratio are configurable. It sits between the calculator core and the external serial interface.

## Interface
- WIDTH, 16, bits per transmitted word (≥2)
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- DIV_W, 32, width of divider value Din
- Clk  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-low; Reset==0 at a Clk edge resets the block
- WrEn  in  1  push WrData into FIFO
- WrData  in  WIDTH  word to transmit
- MsbFirst  in  1  bit order, 1 = MSB first; sampled per word in LOAD
- ConfigDiv  in  1  load Din into pending divider register
- Din  in  DIV_W  half-bit-period in Clk cycles; 0 treated as 1
- Full  out  1  FIFO holds DEPTH words
- Empty  out  1  FIFO holds 0 words
- Level  out  $clog2(DEPTH+1)  FIFO occupancy
- Overflow  out  1  sticky: a write was dropped
- Busy  out  1  FSM in LOAD or SHIFT
- DOutValid  out  1  DataOut carries a valid bit
- DataOut  out  1  serial data
- ClkTx  out  1  serial clock, idle low

## Operation
- Reset values: Full=0, Empty=1, Level=0, Overflow=0, Busy=0, DOutValid=0, DataOut=0, ClkTx=0; pending and active divider = 1; FIFO pointers 0, contents don't-care.
- FIFO: registered count. WrEn with Full=0 writes at tail. WrEn with Full=1 dropped, Overflow set (sticky until reset), even if a pop occurs that cycle. Push and pop in same cycle: Level unchanged. Pointers wrap modulo DEPTH.
- Divider: ConfigDiv=1 loads Din (0→1) into pending register at any time; active divider copied from pending only in LOAD, so a change never corrupts a word in flight. ConfigDiv and LOAD in same cycle: new value used for that word.
- FSM states:
  - IDLE: Busy=0, DOutValid=0, ClkTx=0. Empty=0 → LOAD.
  - LOAD (1 cycle): pop FIFO head into shift register, latch MsbFirst, copy divider, clear bit and period counters. Busy=1, DOutValid=0, ClkTx=0. → SHIFT.
  - SHIFT: WIDTH bit periods, each 2×div Clk cycles. DataOut = current bit (bit WIDTH-1 first if MsbFirst, else bit 0) held the whole period. ClkTx=0 first div cycles, 1 second div cycles (receiver samples on ClkTx rise). DOutValid=1, Busy=1. After last cycle of bit WIDTH-1: Empty=0 → LOAD, else → IDLE.
- DataOut returns to 0 outside SHIFT.
- Reset mid-word: partial word discarded, FIFO flushed, all outputs to reset values at that edge.

## Timing
- FIFO flags/Level update at the Clk edge of the push/pop.
- Push at edge N into empty FIFO, FSM IDLE: Empty=0 after N, LOAD after N+1, first bit on DataOut/DOutValid=1 after N+2.
- Word duration in SHIFT: WIDTH×2×div cycles; total word slot incl. LOAD: WIDTH×2×div+1.
- Back-to-back words: exactly one LOAD cycle with DOutValid=0, ClkTx=0 between words.
- Busy falls in the cycle after the last SHIFT cycle when FIFO empty.

## Test plan
- Reset: hold Reset=0 two cycles with WrEn=1 → all outputs at reset values, Level=0, no transmission.
- Single word: WIDTH=16, div=1, MsbFirst=1, push 16'hABCD → DataOut 1,0,1,0,1,0,1,1,1,1,0,0,1,1,0,1, each held 2 cycles, ClkTx 0/1 per bit, DOutValid high 32 cycles, first bit 2 cycles after push.
- LSB-first + divider: ConfigDiv=1, Din=2, MsbFirst=0, push 16'h000A → bits 0,1,0,1,0… each 4 cycles, ClkTx 2 low/2 high.
- Fill/overflow: DEPTH=4, push 5 words while first transmits slowly → Full=1 at Level=4, fifth dropped, Overflow=1, words 1–4 sent in order with one-cycle LOAD gaps.
- Divider change mid-word: during word 1 (div=1) ConfigDiv with Din=3 → word 1 keeps 2-cycle bits, word 2 uses 6-cycle bits; Din=0 later → treated as 1.
- Reset mid-word: Reset=0 after 5 bits of word 1 with 2 queued → outputs to reset values, Level=0, no further bits.

Source files
------------

// File: rtl/calc_serial_tx.sv
// Serial transmit unit: FIFO-buffered result words shifted out on DataOut with a
// generated ClkTx (low for the first half of each bit period, high for the second).
module calc_serial_tx #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int DIV_W = 32
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         WrEn,
  input  logic [WIDTH-1:0]             WrData,
  input  logic                         MsbFirst,
  input  logic                         ConfigDiv,
  input  logic [DIV_W-1:0]             Din,
  output logic                         Full,
  output logic                         Empty,
  output logic [$clog2(DEPTH+1)-1:0]   Level,
  output logic                         Overflow,
  output logic                         Busy,
  output logic                         DOutValid,
  output logic                         DataOut,
  output logic                         ClkTx
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int BIT_W = $clog2(WIDTH);
  localparam int PER_W = DIV_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT
  } state_t;

  state_t           r_state;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_count;
  logic             r_overflow;

  logic [DIV_W-1:0] r_div_pend;
  logic [DIV_W-1:0] r_div_act;

  logic [WIDTH-1:0] r_shift;
  logic             r_msb_first;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [PER_W-1:0] r_per_cnt;

  logic             r_busy;
  logic             r_dout_valid;
  logic             r_data_out;
  logic             r_clk_tx;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [DIV_W-1:0] w_din_sat;
  logic [DIV_W-1:0] w_div_load;
  logic [WIDTH-1:0] w_head;
  logic [PER_W-1:0] w_per_nxt;
  logic [PER_W-1:0] w_per_last;
  logic             w_bit_end;
  logic             w_word_end;

  assign w_full     = (r_count == LVL_W'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = WrEn && !w_full;
  assign w_pop      = (r_state == S_LOAD);
  assign w_din_sat  = (Din == '0) ? DIV_W'(1) : Din;
  // A divider written in the LOAD cycle itself applies to the word being loaded.
  assign w_div_load = ConfigDiv ? w_din_sat : r_div_pend;
  assign w_head     = r_mem[r_rd_ptr];

  // A bit period spans 2*div cycles; r_per_cnt runs 0 .. 2*div-1.
  assign w_per_nxt  = r_per_cnt + PER_W'(1);
  assign w_per_last = {r_div_act, 1'b0} - PER_W'(1);
  assign w_bit_end  = (r_per_cnt == w_per_last);
  assign w_word_end = w_bit_end && (r_bit_cnt == BIT_W'(WIDTH - 1));

  // NOTE: the storage array is deliberately not reset; pointers and count alone
  // define which entries are valid, so a reset port here would only cost area.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= WrData;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LVL_W'(1);
        2'b01:   r_count <= r_count - LVL_W'(1);
        default: r_count <= r_count;
      endcase
      // Full is judged before any same-cycle pop, so such a write is still lost.
      if (WrEn && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_div_pend <= DIV_W'(1);
    end else if (ConfigDiv) begin
      r_div_pend <= w_din_sat;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state      <= S_IDLE;
      r_div_act    <= DIV_W'(1);
      r_shift      <= '0;
      r_msb_first  <= 1'b0;
      r_bit_cnt    <= '0;
      r_per_cnt    <= '0;
      r_busy       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_data_out   <= 1'b0;
      r_clk_tx     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end

        S_LOAD: begin
          r_state      <= S_SHIFT;
          r_shift      <= w_head;
          r_msb_first  <= MsbFirst;
          r_div_act    <= w_div_load;
          r_bit_cnt    <= '0;
          r_per_cnt    <= '0;
          r_dout_valid <= 1'b1;
          r_clk_tx     <= 1'b0;
          r_data_out   <= MsbFirst ? w_head[WIDTH-1] : w_head[0];
        end

        S_SHIFT: begin
          if (w_word_end) begin
            r_state      <= w_empty ? S_IDLE : S_LOAD;
            r_busy       <= !w_empty;
            r_dout_valid <= 1'b0;
            r_data_out   <= 1'b0;
            r_clk_tx     <= 1'b0;
            r_bit_cnt    <= '0;
            r_per_cnt    <= '0;
          end else if (w_bit_end) begin
            // The outgoing bit always sits at one end of r_shift; present its neighbour next.
            r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
            r_per_cnt  <= '0;
            r_clk_tx   <= 1'b0;
            r_shift    <= r_msb_first ? (r_shift << 1) : (r_shift >> 1);
            r_data_out <= r_msb_first ? r_shift[WIDTH-2] : r_shift[1];
          end else begin
            r_per_cnt <= w_per_nxt;
            r_clk_tx  <= (w_per_nxt >= {1'b0, r_div_act});
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_dout_valid <= 1'b0;
          r_data_out   <= 1'b0;
          r_clk_tx     <= 1'b0;
        end
      endcase
    end
  end

  assign Full      = w_full;
  assign Empty     = w_empty;
  assign Level     = r_count;
  assign Overflow  = r_overflow;
  assign Busy      = r_busy;
  assign DOutValid = r_dout_valid;
  assign DataOut   = r_data_out;
  assign ClkTx     = r_clk_tx;

endmodule

// File: tb/tb_calc_serial_tx.sv
// Directed bench for calc_serial_tx: a monitor decodes each serial word as a receiver
// would (sampling on ClkTx rise) and the test compares against hand-computed patterns.
module tb_calc_serial_tx;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int DIV_W = 32;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int MAXC  = 512;
  localparam int TMO   = 3000;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             WrEn;
  logic [WIDTH-1:0] WrData;
  logic             MsbFirst;
  logic             ConfigDiv;
  logic [DIV_W-1:0] Din;
  logic             Full;
  logic             Empty;
  logic [LVL_W-1:0] Level;
  logic             Overflow;
  logic             Busy;
  logic             DOutValid;
  logic             DataOut;
  logic             ClkTx;

  always #5 Clk = ~Clk;

  calc_serial_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .WrEn      (WrEn),
    .WrData    (WrData),
    .MsbFirst  (MsbFirst),
    .ConfigDiv (ConfigDiv),
    .Din       (Din),
    .Full      (Full),
    .Empty     (Empty),
    .Level     (Level),
    .Overflow  (Overflow),
    .Busy      (Busy),
    .DOutValid (DOutValid),
    .DataOut   (DataOut),
    .ClkTx     (ClkTx)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- receiver-side monitor ----------------
  typedef struct {
    logic [WIDTH-1:0] bits;     // first transmitted bit at the MSB
    int               cycles;   // cycles with DOutValid=1
    bit               shape_ok; // data steady per period, ClkTx low then high halves
    int               gap;      // idle cycles before this word
  } rx_t;

  rx_t  rx_q[$];
  bit   mon_en = 1'b0;
  logic d_hist [MAXC];
  logic c_hist [MAXC];
  int   cur_cnt = 0;
  int   idle_cnt = 0;
  int   gap_at_start = 0;
  int   idle_viol = 0;
  bit   in_word = 1'b0;

  function automatic rx_t decode(input int cycles, input int gap);
    rx_t r;
    int  half;
    r.cycles   = cycles;
    r.gap      = gap;
    r.bits     = '0;
    r.shape_ok = 1'b1;
    half = cycles / (2 * WIDTH);
    if (half == 0 || (cycles % (2 * WIDTH)) != 0 || cycles > MAXC) begin
      r.shape_ok = 1'b0;
    end else begin
      for (int b = 0; b < WIDTH; b++) r.bits[WIDTH-1-b] = d_hist[b*2*half + half];
      for (int i = 0; i < cycles; i++) begin
        if (c_hist[i] !== ((i % (2 * half)) >= half)) r.shape_ok = 1'b0;
        if (d_hist[i] !== d_hist[(i / (2 * half)) * 2 * half]) r.shape_ok = 1'b0;
      end
    end
    return r;
  endfunction

  always @(negedge Clk) begin
    if (mon_en) begin
      if (DOutValid === 1'b1) begin
        if (!in_word) begin
          in_word      = 1'b1;
          cur_cnt      = 0;
          gap_at_start = idle_cnt;
        end
        if (cur_cnt < MAXC) begin
          d_hist[cur_cnt] = DataOut;
          c_hist[cur_cnt] = ClkTx;
        end
        cur_cnt++;
      end else begin
        if (in_word) begin
          rx_q.push_back(decode(cur_cnt, gap_at_start));
          in_word  = 1'b0;
          idle_cnt = 0;
        end
        idle_cnt++;
        if (DataOut !== 1'b0 || ClkTx !== 1'b0) idle_viol++;
      end
    end
  end

  // ---------------- stimulus helpers (all called at a negedge) ----------------
  task automatic push(input logic [WIDTH-1:0] d);
    WrEn   = 1'b1;
    WrData = d;
    @(negedge Clk);
    WrEn   = 1'b0;
  endtask

  task automatic cfg_div(input logic [DIV_W-1:0] v);
    ConfigDiv = 1'b1;
    Din       = v;
    @(negedge Clk);
    ConfigDiv = 1'b0;
  endtask

  // load=1 waits for a LOAD cycle (Busy=1, DOutValid=0), else for DOutValid=1.
  task automatic wait_state(input string name, input bit load);
    int t = 0;
    while (t < TMO && !(load ? (Busy === 1'b1 && DOutValid === 1'b0) : (DOutValid === 1'b1))) begin
      @(negedge Clk);
      t++;
    end
    if (t >= TMO) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: timeout after %0d cycles", name, t);
    end
  endtask

  task automatic get_word(input string name, output rx_t w);
    int t = 0;
    while (rx_q.size() == 0 && t < TMO) begin
      @(negedge Clk);
      t++;
    end
    if (rx_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: timeout waiting for word", name);
      w.bits = '0; w.cycles = -1; w.shape_ok = 1'b0; w.gap = -1;
    end else begin
      w = rx_q.pop_front();
    end
  endtask

  task automatic expect_word(input string name, input logic [WIDTH-1:0] exp_seq,
                             input int exp_cycles, input bit chk_gap);
    rx_t w;
    get_word(name, w);
    check({name, "_bits"},   32'(w.bits),     32'(exp_seq));
    check({name, "_cycles"}, 32'(w.cycles),   32'(exp_cycles));
    check({name, "_shape"},  32'(w.shape_ok), 32'd1);
    if (chk_gap) check({name, "_gap"}, 32'(w.gap), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [DIV_W-1:0] din;
    logic             msb;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] exp_seq;    // hand-written in transmit order
    int               exp_cycles; // 16 bits * 2 * div
  } vec_t;

  vec_t vecs[5];

  initial begin
    rx_t w;
    int  exp_lvl [5];
    bit  exp_full[5];
    bit  exp_ovf [5];

    vecs[0] = '{32'd1, 1'b1, 16'hABCD, 16'hABCD, 32};
    vecs[1] = '{32'd2, 1'b0, 16'h000A, 16'h5000, 64};
    vecs[2] = '{32'd0, 1'b0, 16'h8001, 16'h8001, 32};
    vecs[3] = '{32'd3, 1'b1, 16'h1234, 16'h1234, 96};
    vecs[4] = '{32'd1, 1'b0, 16'hF0F0, 16'h0F0F, 32};

    exp_lvl  = '{1, 2, 3, 4, 4};
    exp_full = '{0, 0, 0, 1, 1};
    exp_ovf  = '{0, 0, 0, 0, 1};

    // Reset held two edges with WrEn asserted.
    Reset = 1'b0; WrEn = 1'b1; WrData = 16'hFFFF;
    MsbFirst = 1'b1; ConfigDiv = 1'b0; Din = '0;
    repeat (2) @(negedge Clk);
    check("rst_full",     32'(Full),      32'd0);
    check("rst_empty",    32'(Empty),     32'd1);
    check("rst_level",    32'(Level),     32'd0);
    check("rst_overflow", 32'(Overflow),  32'd0);
    check("rst_busy",     32'(Busy),      32'd0);
    check("rst_dvalid",   32'(DOutValid), 32'd0);
    check("rst_dataout",  32'(DataOut),   32'd0);
    check("rst_clktx",    32'(ClkTx),     32'd0);
    Reset = 1'b1; WrEn = 1'b0;
    mon_en = 1'b1;
    repeat (4) @(negedge Clk);
    check("post_rst_level", 32'(Level),      32'd0);
    check("post_rst_busy",  32'(Busy),       32'd0);
    check("post_rst_noword", 32'(rx_q.size()), 32'd0);

    // Single words: latency, bit order, divider, ClkTx shape.
    for (int i = 0; i < 5; i++) begin
      MsbFirst = vecs[i].msb;
      cfg_div(vecs[i].din);
      push(vecs[i].word);
      check($sformatf("v%0d_empty_n", i), 32'(Empty), 32'd0);
      check($sformatf("v%0d_idle", i),    32'(Busy),  32'd0);
      @(negedge Clk);
      check($sformatf("v%0d_load_busy", i),  32'(Busy),      32'd1);
      check($sformatf("v%0d_load_dv", i),    32'(DOutValid), 32'd0);
      @(negedge Clk);
      check($sformatf("v%0d_first_dv", i),   32'(DOutValid), 32'd1);
      check($sformatf("v%0d_first_bit", i),  32'(DataOut),   32'(vecs[i].exp_seq[WIDTH-1]));
      expect_word($sformatf("v%0d", i), vecs[i].exp_seq, vecs[i].exp_cycles, 1'b0);
      check($sformatf("v%0d_busy_end", i),   32'(Busy),  32'd0);
      check($sformatf("v%0d_level_end", i),  32'(Level), 32'd0);
    end

    // Fill and overflow while a slow word (div=3) is on the wire.
    MsbFirst = 1'b1;
    cfg_div(32'd3);
    push(16'hC3A5);
    wait_state("ovf_first_dv", 1'b0);
    for (int i = 0; i < 5; i++) begin
      push(16'h1001 * (i + 1));
      check($sformatf("ovf_level%0d", i), 32'(Level),    32'(exp_lvl[i]));
      check($sformatf("ovf_full%0d", i),  32'(Full),     32'(exp_full[i]));
      check($sformatf("ovf_ovf%0d", i),   32'(Overflow), 32'(exp_ovf[i]));
    end
    // Write while full in the same cycle as a pop: still dropped.
    wait_state("ovf_load1", 1'b1);
    push(16'h6006);
    check("ovf_full_pop_level", 32'(Level), 32'd3);
    check("ovf_full_pop_full",  32'(Full),  32'd0);
    // Push and pop together when not full: level unchanged.
    wait_state("ovf_load2", 1'b1);
    push(16'h7007);
    check("ovf_pushpop_level", 32'(Level), 32'd3);
    expect_word("ovf_w0", 16'hC3A5, 96, 1'b0);
    expect_word("ovf_w1", 16'h1001, 96, 1'b1);
    expect_word("ovf_w2", 16'h2002, 96, 1'b1);
    expect_word("ovf_w3", 16'h3003, 96, 1'b1);
    expect_word("ovf_w4", 16'h4004, 96, 1'b1);
    expect_word("ovf_w7", 16'h7007, 96, 1'b1);
    check("ovf_sticky", 32'(Overflow), 32'd1);
    check("ovf_empty",  32'(Empty),    32'd1);

    // Divider changes: mid-word (deferred) and in the LOAD cycle (immediate, 0 -> 1).
    MsbFirst = 1'b0;
    cfg_div(32'd1);
    push(16'h0001);
    push(16'h00FF);
    push(16'h1234);
    wait_state("div_w1_dv", 1'b0);
    cfg_div(32'd3);
    wait_state("div_w2_load", 1'b1);
    wait_state("div_w2_dv", 1'b0);
    wait_state("div_w3_load", 1'b1);
    cfg_div(32'd0);
    expect_word("div_w1", 16'h8000, 32, 1'b0);
    expect_word("div_w2", 16'hFF00, 96, 1'b1);
    expect_word("div_w3", 16'h2C48, 32, 1'b1);

    // Reset after five bits of a word with two more queued.
    MsbFirst = 1'b1;
    cfg_div(32'd1);
    push(16'hFFFF);
    push(16'h1111);
    push(16'h2222);
    wait_state("mid_dv", 1'b0);
    repeat (9) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("mid_rst_dvalid",   32'(DOutValid), 32'd0);
    check("mid_rst_dataout",  32'(DataOut),   32'd0);
    check("mid_rst_clktx",    32'(ClkTx),     32'd0);
    check("mid_rst_busy",     32'(Busy),      32'd0);
    check("mid_rst_level",    32'(Level),     32'd0);
    check("mid_rst_empty",    32'(Empty),     32'd1);
    check("mid_rst_full",     32'(Full),      32'd0);
    check("mid_rst_overflow", 32'(Overflow),  32'd0);
    Reset = 1'b1;
    get_word("mid_partial", w);
    check("mid_partial_cycles", 32'(w.cycles), 32'd10);
    repeat (100) @(negedge Clk);
    check("mid_no_more_words", 32'(rx_q.size()), 32'd0);
    check("mid_idle_busy",     32'(Busy),        32'd0);
    check("mid_idle_level",    32'(Level),       32'd0);

    check("idle_outputs_low", 32'(idle_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
